// File: rtl/serial_subtractor_16bit_pkg.sv
// Shared constants and FSM encoding for the bit-serial subtractor.
package serial_subtractor_16bit_pkg;

  localparam int unsigned WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Gate-level one-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor (
  output logic d,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  logic axb;
  logic na;
  logic naxb;
  logic na_b;
  logic naxb_bin;

  xor g_x0 (axb, a, b);
  xor g_x1 (d, axb, bin);
  not g_n0 (na, a);
  not g_n1 (naxb, axb);
  and g_a0 (na_b, na, b);
  and g_a1 (naxb_bin, naxb, bin);
  or  g_o0 (bout, na_b, naxb_bin);

endmodule

// File: rtl/serial_subtractor_16bit.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell, LSB first, one bit per clock.
module serial_subtractor_16bit
  import serial_subtractor_16bit_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             a_msb;
  logic             b_msb;

  logic             load;
  logic             step;
  logic             last;
  logic             d_bit;
  logic             br_next;

  full_subtractor u_fs (
    .d    (d_bit),
    .bout (br_next),
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered status flags track the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == SHIFT);
      done <= (state_next == DONE);
    end
  end

  // Operand shifters, borrow chain, counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      a_sr  <= a;
      b_sr  <= b;
      br    <= bin;
      cnt   <= '0;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (step) begin
      a_sr <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr <= {1'b0, b_sr[WIDTH-1:1]};
      br   <= br_next;
      cnt  <= cnt + CNT_W'(1);
      diff <= {d_bit, diff[WIDTH-1:1]};
      // The final bit shifted in becomes the result MSB
      if (last) begin
        bout <= br_next;
        ovf  <= (a_msb ^ b_msb) & (d_bit ^ a_msb);
      end
    end
  end

endmodule
